step_clock_gen: RTL and testbench
=================================

Name: step_clock_gen

Overview:
Generates the single-cycle CPU clock-enable (tick) that drives the TD4 mother board from the board clock. It sits between the raw board pins and the mother board's control bus, and replaces a bare prescaled clock. Two modes, selected by a slide switch: auto (free-running divider) and manual (one tick per debounced step-button press). Both raw inputs are synchronised and debounced inside the block.

Parameters:
AUTO_DIV, 100_000_000, clk cycles per auto-mode tick period; must be >= 2
DEBOUNCE_CYCLES, 1_000_000, cycles an input must hold a new level before it is accepted; must be >= 2

Ports:
clk  input  1  board clock; the only clock in the block
rst  input  1  asynchronous, active-high reset
btn_step  input  1  raw step push-button, asynchronous to clk, 1 = pressed
sw_mode  input  1  raw mode switch, asynchronous to clk; 0 = auto, 1 = manual
tick  output  1  registered clock-enable, high for exactly one clk cycle per step
mode  output  1  debounced mode currently in effect (for LED display)

Behaviour:
- Reset: asynchronous and active-high. While rst is high, all flops are cleared: tick=0, mode=0 (auto), divider=0, FSM=S_IDLE, and synchronisers/debouncers=0. tick falls immediately on rst assertion, even mid-pulse.
- Synchronisers: a 2-flop chain on each of btn_step and sw_mode. The synchronised level is valid 2 edges after a raw change.
- Debouncer, per input:
  - Holds state db and counter cnt, width $clog2(DEBOUNCE_CYCLES).
  - If sync == db: cnt <= 0.
  - Otherwise cnt increments each edge. On the edge where cnt == DEBOUNCE_CYCLES-1: db <= sync and cnt <= 0.
  - A level that returns before acceptance clears cnt. No partial credit.
- Auto mode (mode==0):
  - Divider div counts 0..AUTO_DIV-1 and wraps to 0.
  - tick <= (div == AUTO_DIV-1). After reset, the first tick is high in the cycle following edge AUTO_DIV; period is AUTO_DIV cycles.
  - Button is ignored; FSM held in S_IDLE.
- Manual mode (mode==1): div is held at 0. FSM states, with tick <= 1 only on the S_IDLE->S_FIRE transition:
  - S_IDLE: btn_db==1 -> S_FIRE
  - S_FIRE: -> S_HOLD unconditionally (exactly one tick per press)
  - S_HOLD: btn_db==0 -> S_IDLE
- Manual latency: from a raw press, the synchronised level is valid after edge 2, btn_db rises at edge 2+DEBOUNCE_CYCLES, and tick is high for the single cycle after edge 3+DEBOUNCE_CYCLES.
- Mode change, on the edge the mode debouncer updates:
  - div is cleared to 0 and tick <= 0 that edge.
  - On entering manual: FSM goes to S_HOLD if btn_db==1 (a held button does not fire), else S_IDLE.
  - On entering auto: FSM goes to S_IDLE.
- Simultaneous debounced button rise and mode change on the same edge: the mode change wins and no tick is issued.
- tick never asserts on two consecutive cycles in any mode, since AUTO_DIV >= 2.

Optional Feature:
Macro: STEP_CLOCK_FAST_EN
- Defined:
  - Adds parameter FAST_DIV (default 10_000_000) and input port sw_fast (raw, debounced by a third debouncer instance).
  - In auto mode the divider terminal count is FAST_DIV-1 when fast_db==1, else AUTO_DIV-1.
  - A change of fast_db clears div, like a mode change.
- Undefined: no sw_fast port, no third debouncer; single auto rate only.

Decomposition:
- Package step_clock_pkg: step_state_t enum {S_IDLE, S_FIRE, S_HOLD}, and the default constants AUTO_DIV_DEFAULT and DEBOUNCE_DEFAULT.
- Sub-module debouncer, instantiated per input. Parameter CYCLES; ports clk, rst, raw, level. It contains the 2-flop synchroniser and the counter.
- The divider and FSM stay in step_clock_gen.

Test Plan:
1. AUTO_DIV=5, DEBOUNCE_CYCLES=4, sw_mode=0 from reset, release rst -> tick high in the cycles after edges 5, 10, 15; low otherwise; mode=0.
2. Manual: sw_mode=1 held, btn_step raised at edge 0 and held 20 cycles -> tick high only in the cycle after edge 7; a single tick per press; second press after release gives a second tick.
3. Glitch: in manual, btn_step high for 3 cycles then low -> no tick; internal debounce counter returns to 0.
4. Mode switch while button held: btn held, sw_mode 0->1 -> mode=1 after debounce, no tick until the button is released and pressed again.
5. Reset mid-pulse: assert rst asynchronously during the tick-high cycle -> tick=0 immediately, mode=0, and after release the first auto tick follows the case-1 timing.
6. With STEP_CLOCK_FAST_EN, FAST_DIV=3, sw_fast=1 -> auto tick period is 3 cycles; toggling sw_fast back to 0 clears div and the period returns to AUTO_DIV.

Source files
------------

// File: rtl/step_clock_pkg.sv
// Shared state type and default constants for the TD4 step clock generator.
package step_clock_pkg;

  localparam int unsigned AUTO_DIV_DEFAULT = 100_000_000;
  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;
  localparam int unsigned FAST_DIV_DEFAULT = 10_000_000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_HOLD = 2'd2
  } step_state_t;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser plus hold-time debouncer for one raw board input.
// accept_c pulses on the edge where level takes its new value.
module debouncer
  import step_clock_pkg::*;
#(
  parameter int unsigned CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic accept_c
);

  localparam int unsigned CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign accept_c = (sync_q2 != level) && (cnt == LAST);

  // Any return to the accepted level discards the accumulated hold time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_q2 == level) begin
      cnt   <= '0;
    end else if (accept_c) begin
      level <= sync_q2;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/step_clock_gen.sv
// TD4 CPU tick generator: free-running divider (auto) or one tick per step press (manual).
// Optional STEP_CLOCK_FAST_EN adds sw_fast and a second, faster auto rate.
module step_clock_gen
  import step_clock_pkg::*;
#(
  parameter int unsigned AUTO_DIV        = AUTO_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef STEP_CLOCK_FAST_EN
  ,
  parameter int unsigned FAST_DIV        = FAST_DIV_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_step,
  input  logic sw_mode,
`ifdef STEP_CLOCK_FAST_EN
  input  logic sw_fast,
`endif
  output logic tick,
  output logic mode
);

`ifdef STEP_CLOCK_FAST_EN
  localparam int unsigned DIV_MAX = (FAST_DIV > AUTO_DIV) ? FAST_DIV : AUTO_DIV;
`else
  localparam int unsigned DIV_MAX = AUTO_DIV;
`endif
  localparam int unsigned DW = $clog2(DIV_MAX);

  logic          btn_db;
  logic          btn_acc_c;
  logic          mode_acc_c;
  logic          rate_acc_c;
  logic [DW-1:0] tc_c;

  step_state_t   state;
  step_state_t   state_n;
  logic [DW-1:0] div;
  logic [DW-1:0] div_n;
  logic          tick_n;

  debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk      (clk),
    .rst      (rst),
    .raw      (btn_step),
    .level    (btn_db),
    .accept_c (btn_acc_c)
  );

  debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk      (clk),
    .rst      (rst),
    .raw      (sw_mode),
    .level    (mode),
    .accept_c (mode_acc_c)
  );

`ifdef STEP_CLOCK_FAST_EN
  logic fast_db;

  debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_fast_db (
    .clk      (clk),
    .rst      (rst),
    .raw      (sw_fast),
    .level    (fast_db),
    .accept_c (rate_acc_c)
  );

  assign tc_c = fast_db ? DW'(FAST_DIV - 1) : DW'(AUTO_DIV - 1);
`else
  assign rate_acc_c = 1'b0;
  assign tc_c       = DW'(AUTO_DIV - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      div   <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      div   <= div_n;
      tick  <= tick_n;
    end
  end

  // A mode change overrides everything on its edge; btn level is taken post-update
  // so a button accepted on the same edge counts as already held.
  always_comb begin
    state_n = state;
    div_n   = div;
    tick_n  = 1'b0;
    if (mode_acc_c) begin
      div_n   = '0;
      state_n = (!mode && (btn_db ^ btn_acc_c)) ? S_HOLD : S_IDLE;
    end else if (!mode) begin
      state_n = S_IDLE;
      if (rate_acc_c) begin
        div_n = '0;
      end else if (div == tc_c) begin
        div_n  = '0;
        tick_n = 1'b1;
      end else begin
        div_n = div + DW'(1);
      end
    end else begin
      div_n = '0;
      case (state)
        S_IDLE: begin
          if (btn_db) begin
            state_n = S_FIRE;
            tick_n  = 1'b1;
          end
        end
        S_FIRE:  state_n = S_HOLD;
        S_HOLD:  if (!btn_db) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// Directed bench for step_clock_gen: expected tick edges are queued by the stimulus
// and a negedge monitor pops one entry per observed tick.
module tb_step_clock_gen;

  localparam int unsigned AUTO_DIV = 5;
  localparam int unsigned DEB      = 4;
  localparam int unsigned FAST_DIV = 3;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic btn_step = 1'b0;
  logic sw_mode  = 1'b0;
`ifdef STEP_CLOCK_FAST_EN
  logic sw_fast  = 1'b0;
`endif
  logic tick;
  logic mode;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int exp_q[$];

  always #5 clk = ~clk;

  // Edge number since reset release: edge 1 is the first posedge with rst low.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  step_clock_gen #(
    .AUTO_DIV        (AUTO_DIV),
    .DEBOUNCE_CYCLES (DEB)
`ifdef STEP_CLOCK_FAST_EN
    ,
    .FAST_DIV        (FAST_DIV)
`endif
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .btn_step (btn_step),
    .sw_mode  (sw_mode),
`ifdef STEP_CLOCK_FAST_EN
    .sw_fast  (sw_fast),
`endif
    .tick     (tick),
    .mode     (mode)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_to(input int e);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < e && guard < 2000);
    if (cyc < e) check("run_to_timeout", cyc, e);
  endtask

  task automatic do_reset(input logic m);
    @(negedge clk);
    rst      = 1'b1;
    btn_step = 1'b0;
    sw_mode  = m;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every tick seen must match the next queued edge number.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst && tick) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          check("tick_edge", cyc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_tick", int'(tick), 0);
    check("reset_mode", int'(mode), 0);
    rst = 1'b0;

    // Auto mode from reset: ticks after edges 5, 10, 15, 20
    exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(15); exp_q.push_back(20);
    run_to(22);
    check("auto_queue_empty", exp_q.size(), 0);
    check("auto_mode", int'(mode), 0);

    // Manual from reset: one auto tick before the mode is accepted at edge 6
    do_reset(1'b1);
    exp_q.push_back(5);
    run_to(8);
    check("manual_mode", int'(mode), 1);
    btn_step = 1'b1;
    exp_q.push_back(15);
    run_to(28);
    btn_step = 1'b0;
    run_to(40);
    btn_step = 1'b1;
    exp_q.push_back(47);
    run_to(50);
    btn_step = 1'b0;
    run_to(62);
    check("press_queue_empty", exp_q.size(), 0);

    // Glitch: three raw cycles high never reach acceptance
    btn_step = 1'b1;
    run_to(65);
    btn_step = 1'b0;
    run_to(66);
    check("glitch_cnt_mid", int'(u_dut.u_btn_db.cnt), 2);
    run_to(70);
    check("glitch_cnt_clear", int'(u_dut.u_btn_db.cnt), 0);
    run_to(80);
    check("glitch_queue_empty", exp_q.size(), 0);

    // Button and mode accepted on the same edge: mode change wins, no tick
    do_reset(1'b0);
    exp_q.push_back(5);
    run_to(1);
    btn_step = 1'b1;
    sw_mode  = 1'b1;
    run_to(20);
    check("simul_mode", int'(mode), 1);
    btn_step = 1'b0;
    run_to(35);
    check("simul_queue_empty", exp_q.size(), 0);

    // Mode switched to manual while the button is already held
    do_reset(1'b0);
    exp_q.push_back(5);
    run_to(1);
    btn_step = 1'b1;
    run_to(2);
    sw_mode = 1'b1;
    run_to(20);
    check("held_mode", int'(mode), 1);
    check("held_queue_empty", exp_q.size(), 0);
    run_to(30);
    btn_step = 1'b0;
    run_to(40);
    btn_step = 1'b1;
    exp_q.push_back(47);
    run_to(50);
    btn_step = 1'b0;
    run_to(60);
    check("held_repress_empty", exp_q.size(), 0);

    // Reset asserted during the tick-high cycle
    do_reset(1'b0);
    exp_q.push_back(5);
    run_to(5);
    #2 rst = 1'b1;
    #1;
    check("midreset_tick", int'(tick), 0);
    check("midreset_mode", int'(mode), 0);
    check("midreset_queue", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(5); exp_q.push_back(10);
    run_to(12);
    check("post_reset_queue", exp_q.size(), 0);

`ifdef STEP_CLOCK_FAST_EN
    // Fast rate: accepted at edge 6, period 3; back to AUTO_DIV after edge 25
    sw_fast = 1'b1;
    do_reset(1'b0);
    exp_q.push_back(5); exp_q.push_back(9); exp_q.push_back(12);
    exp_q.push_back(15); exp_q.push_back(18);
    run_to(19);
    sw_fast = 1'b0;
    exp_q.push_back(21); exp_q.push_back(24); exp_q.push_back(30);
    exp_q.push_back(35); exp_q.push_back(40);
    run_to(42);
    check("fast_queue_empty", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
